// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock / reset sequencer.
// - pll_state_e : sequencer FSM states with their fixed debug encodings.
// - LossCountW  : width of the saturating lock-loss event counter.
// - cnt_width() : width of the single cycle counter shared by all states.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_state_e;

  localparam int unsigned LossCountW = 8;

  // The shared counter only ever needs to reach (limit - 1) for the largest limit.
  // The loss filter reuses the same counter, so it is folded into the maximum.
  function automatic int unsigned cnt_width(input int unsigned pll_rst_cycles,
                                            input int unsigned lock_timeout,
                                            input int unsigned stable_cycles,
                                            input int unsigned loss_filter);
    int unsigned m;
    m = pll_rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (loss_filter > m) m = loss_filter;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned DefaultCntW = cnt_width(16, 50000, 1024, 4);

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop bit synchronizer for bringing an asynchronous level into clk_i.
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset, clears every stage to 0
//   d_i   - asynchronous input level
//   q_o   - synchronized level, Depth cycles of latency
module pll_lock_sync #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// PLL lock monitor and downstream reset sequencer, clocked by the board reference clock.
// Holds the PLL in reset, waits for lock (with timeout and retry), requires a stable
// lock window before releasing the system, restarts the PLL on filtered lock loss and
// latches a sticky fault after MAX_RETRIES lock timeouts.
// Ports:
//   refclk      - free-running reference clock
//   rst         - asynchronous active-high reset
//   locked      - PLL lock indication (asynchronous)
//   pll_rst     - reset to the PLL
//   sys_rst     - active-high reset to downstream logic
//   ready       - lock stable, downstream released
//   fault       - sticky lock failure
//   retry_count - lock timeouts in the current bring-up
//   loss_count  - saturating count of lock-loss events since rst
//   state       - current FSM state (debug)
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 4,
  parameter int unsigned LOSS_FILTER    = 4
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               locked,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [LossCountW-1:0]              loss_count,
  output logic [2:0]                         state
);

  localparam int unsigned CntW   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                             LOSS_FILTER);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  logic locked_s;

  pll_lock_sync #(
    .Depth(2)
  ) u_lock_sync (
    .clk_i(refclk),
    .rst_i(rst),
    .d_i  (locked),
    .q_o  (locked_s)
  );

  pll_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RetryW-1:0]     retry_q, retry_d;
  logic [LossCountW-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (locked_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + RetryW'(1);
          cnt_d   = '0;
          state_d = (retry_d == RetryW'(MAX_RETRIES)) ? StFault : StPllRst;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // Counter tracks the current run of consecutive low lock samples.
        if (locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(LOSS_FILTER - 1)) begin
          state_d = StPllRst;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + LossCountW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they move together with the state register.
    pll_rst_d = (state_d == StPllRst) || (state_d == StFault);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fault_d   = (state_d == StFault);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
module tb_pll_lock_reset_sequencer;

  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int MR  = 2;
  localparam int LF  = 3;
  localparam int RW  = $clog2(MR + 1);

  localparam int PhReset  = 0;
  localparam int PhWait   = 1;
  localparam int PhStable = 2;
  localparam int PhRun    = 3;
  localparam int PhFault  = 4;

  logic          refclk = 1'b0;
  logic          rst;
  logic          locked;
  logic          pll_rst, sys_rst, ready, fault;
  logic [RW-1:0] retry_count;
  logic [7:0]    loss_count;
  logic [2:0]    state;

  pll_lock_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR),
    .LOSS_FILTER   (LF)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .loss_count (loss_count),
    .state      (state)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry;
    logic [7:0]    loss;
    logic [2:0]    st;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  int   ph, t, low_run, retries, losses;
  bit   sh0, sh1;
  bit   cur_lk, cur_rst;

  task automatic model_reset();
    ph = PhReset; t = 0; low_run = 0; retries = 0; losses = 0;
    sh0 = 1'b0; sh1 = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    if (cur_rst) begin
      model_reset();
      return;
    end
    ls  = sh1;
    sh1 = sh0;
    sh0 = cur_lk;
    case (ph)
      PhReset: begin
        t++;
        if (t == PRC) begin ph = PhWait; t = 0; end
      end
      PhWait: begin
        if (ls) begin
          ph = PhStable; t = 0;
        end else begin
          t++;
          if (t == LT) begin
            retries++;
            ph = (retries == MR) ? PhFault : PhReset;
            t  = 0;
          end
        end
      end
      PhStable: begin
        if (!ls) begin
          ph = PhWait; t = 0;
        end else begin
          t++;
          if (t == SC) begin ph = PhRun; t = 0; retries = 0; end
        end
      end
      PhRun: begin
        low_run = ls ? 0 : low_run + 1;
        if (low_run == LF) begin
          if (losses < 255) losses++;
          ph = PhReset; t = 0; low_run = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.pll_rst = (ph == PhReset) || (ph == PhFault);
    o.sys_rst = (ph != PhRun);
    o.ready   = (ph == PhRun);
    o.fault   = (ph == PhFault);
    o.retry   = RW'(retries);
    o.loss    = 8'(losses);
    o.st      = 3'(ph);
    return o;
  endfunction

  task automatic step(input bit lk, input bit r);
    @(posedge refclk);
    #1;
    model_edge();
    cur_lk = lk;
    cur_rst = r;
    locked = lk;
    rst = r;
    if (r) model_reset();
    exp_q.push_back(model_out());
    cyc++;
  endtask

  task automatic drive_n(input bit lk, input int n);
    repeat (n) step(lk, 1'b0);
  endtask

  task automatic reset_n(input bit lk, input int n);
    repeat (n) step(lk, 1'b1);
  endtask

  task automatic check_val(input string what, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d got=%0h want=%0h", what, cyc, got, want);
    end
  endtask

  task automatic check_reset_vals(input string what);
    #1;
    check_val({what, " pll_rst"}, 32'(pll_rst), 32'd1);
    check_val({what, " sys_rst"}, 32'(sys_rst), 32'd1);
    check_val({what, " ready"}, 32'(ready), 32'd0);
    check_val({what, " fault"}, 32'(fault), 32'd0);
    check_val({what, " retry_count"}, 32'(retry_count), 32'd0);
    check_val({what, " loss_count"}, 32'(loss_count), 32'd0);
    check_val({what, " state"}, 32'(state), 32'd0);
  endtask

  task automatic check_fault_vals(input string what);
    #1;
    check_val({what, " fault"}, 32'(fault), 32'd1);
    check_val({what, " pll_rst"}, 32'(pll_rst), 32'd1);
    check_val({what, " sys_rst"}, 32'(sys_rst), 32'd1);
    check_val({what, " ready"}, 32'(ready), 32'd0);
    check_val({what, " state"}, 32'(state), 32'd4);
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge refclk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {pll_rst, sys_rst, ready, fault, retry_count, loss_count, state};
        n_total++;
        if (a === e) begin
          n_pass++;
        end else begin
          $display("FAIL outputs cyc=%0d got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d loss=%0d state=%0d want pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d loss=%0d state=%0d",
                   cyc, a.pll_rst, a.sys_rst, a.ready, a.fault, a.retry, a.loss, a.st,
                   e.pll_rst, e.sys_rst, e.ready, e.fault, e.retry, e.loss, e.st);
        end
      end
    end
  end

  initial begin
    int len;
    bit lk;
    rst = 1'b1;
    locked = 1'b0;
    cur_rst = 1'b1;
    cur_lk = 1'b0;
    model_reset();

    reset_n(1'b1, 2);
    drive_n(1'b1, 20);
    drive_n(1'b0, 2);
    drive_n(1'b1, 6);
    drive_n(1'b0, 4);
    drive_n(1'b1, 25);
    reset_n(1'b1, 1);
    check_reset_vals("reset in RUN");
    reset_n(1'b1, 1);
    drive_n(1'b0, 30);
    drive_n(1'b1, 40);
    reset_n(1'b0, 2);
    drive_n(1'b0, 60);
    check_fault_vals("expired wait");
    reset_n(1'b0, 1);
    check_reset_vals("reset in FAULT");
    drive_n(1'b1, 20);
    reset_n(1'b1, 2);
    drive_n(1'b1, 9);
    drive_n(1'b0, 1);
    drive_n(1'b1, 30);
    reset_n(1'b1, 2);
    drive_n(1'b1, 8);
    reset_n(1'b1, 1);
    check_reset_vals("reset in STABLE");
    drive_n(1'b1, 20);
    repeat (270) begin
      drive_n(1'b1, 20);
      drive_n(1'b0, 5);
    end
    drive_n(1'b1, 20);
    reset_n(1'b1, 1);
    repeat (150) begin
      len = int'($urandom_range(1, 30));
      lk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) reset_n(lk, int'($urandom_range(1, 2)));
      drive_n(lk, len);
    end

    @(negedge refclk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
